// File: rtl/register_file.sv
// SimpleRisc architectural register file: 16x32, two combinational read ports, one write port.
// Optional RF_WR_BYPASS_EN forwards the in-flight write-back to a matching read port.

module rf_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (we) q <= d;
  end
endmodule

module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              is_ret,
  input  logic              is_st,
  input  logic              is_wb,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] RA_IDX = ADDR_W'(NREGS - 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  wb_req_t                       wb;
  logic [NREGS-1:0][DATA_W-1:0]  regs;
  logic [ADDR_W-1:0]             rd, rs1, rs2, rd1_adr, rd2_adr;
  logic                          unused_insn_bits;

  assign wb = '{we: is_wb, adr: wr_adr, data: wr_data};

  assign rd  = instruction[25:22];
  assign rs1 = instruction[21:18];
  assign rs2 = instruction[17:14];
  assign unused_insn_bits = ^{instruction[31:26], instruction[13:0]};

  assign rd1_adr = is_ret ? RA_IDX : rs1;
  assign rd2_adr = is_st  ? rd     : rs2;

  genvar g;
  generate
    for (g = 0; g < NREGS; g++) begin : g_reg
      rf_cell #(.DATA_W(DATA_W)) u_cell (
        .clk   (clk),
        .reset (reset),
        .we    (wb.we && (wb.adr == ADDR_W'(g))),
        .d     (wb.data),
        .q     (regs[g])
      );
    end
  endgenerate

`ifdef RF_WR_BYPASS_EN
  // Reset suppresses forwarding, since the write itself is discarded on that edge.
  always_comb begin
    op1 = regs[rd1_adr];
    op2 = regs[rd2_adr];
    if (wb.we && !reset && (wb.adr == rd1_adr)) op1 = wb.data;
    if (wb.we && !reset && (wb.adr == rd2_adr)) op2 = wb.data;
  end
`else
  assign op1 = regs[rd1_adr];
  assign op2 = regs[rd2_adr];
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default and RF_WR_BYPASS_EN builds).

module tb_register_file;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        is_ret, is_st, is_wb;
  logic [3:0]  wr_adr;
  logic [31:0] wr_data;
  logic [31:0] op1, op2;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .is_ret      (is_ret),
    .is_st       (is_st),
    .is_wb       (is_wb),
    .wr_adr      (wr_adr),
    .wr_data     (wr_data),
    .op1         (op1),
    .op2         (op2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [3:0] rs2, input logic [31:0] noise);
    logic [31:0] w;
    w = noise & 32'hFC00_3FFF;
    w[25:22] = rd;
    w[21:18] = rs1;
    w[17:14] = rs2;
    return w;
  endfunction

  initial begin
    // 1: reset held two cycles with a competing write
    reset = 1'b1; is_wb = 1'b1; wr_adr = 4'd3; wr_data = 32'd7;
    is_ret = 1'b0; is_st = 1'b0; instruction = mk(4'd0, 4'd3, 4'd3, 32'h0);
    tick();
    chk("reset_op1_c1", op1, 32'd0);
    tick();
    chk("reset_op2_c2", op2, 32'd0);
    reset = 1'b0; is_wb = 1'b0;
    #1;
    chk("post_reset_op1", op1, 32'd0);
    chk("post_reset_op2", op2, 32'd0);

    // 2: write r[i] = 10*i, then sweep both ports
    is_wb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_adr = 4'(i); wr_data = 32'(10 * i);
      tick();
    end
    is_wb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      instruction = mk(4'd0, 4'(i), 4'(15 - i), 32'hFFFF_FFFF);
      #1;
      chk($sformatf("sweep_op1_r%0d", i), op1, 32'(10 * i));
      chk($sformatf("sweep_op2_r%0d", 15 - i), op2, 32'(10 * (15 - i)));
    end
    instruction = mk(4'd0, 4'd7, 4'd7, 32'h0);
    #1;
    chk("same_reg_op1", op1, 32'd70);
    chk("same_reg_op2", op2, 32'd70);

    // 3: ret forces op1 to r15
    instruction = 32'h0024_0000;
    is_ret = 1'b1; #1;
    chk("ret_op1", op1, 32'd150);
    is_ret = 1'b0; #1;
    chk("noret_op1", op1, 32'd90);

    // 4: store takes op2 from rd
    instruction = 32'h0280_0000;
    is_st = 1'b1; #1;
    chk("st_op2", op2, 32'd100);
    is_st = 1'b0; #1;
    chk("nost_op2", op2, 32'd0);

    // both flags together, each acting on its own port
    instruction = 32'h02A4_0000 | 32'h0000_0000;
    instruction[17:14] = 4'd3;
    is_ret = 1'b1; is_st = 1'b1; #1;
    chk("both_op1", op1, 32'd150);
    chk("both_op2", op2, 32'd100);
    is_ret = 1'b0; is_st = 1'b0; #1;
    chk("neither_op1", op1, 32'd90);
    chk("neither_op2", op2, 32'd30);

    // 5: same-cycle write/read of r5
    instruction = mk(4'd0, 4'd5, 4'd0, 32'h0);
    is_wb = 1'b1; wr_adr = 4'd5; wr_data = 32'd99;
    #1;
`ifdef RF_WR_BYPASS_EN
    chk("wr_rd_before_edge", op1, 32'd99);
`else
    chk("wr_rd_before_edge", op1, 32'd50);
`endif
    chk("wr_rd_other_port", op2, 32'd0);
    tick();
    is_wb = 1'b0; #1;
    chk("wr_rd_after_edge", op1, 32'd99);

    // write to r15 while ret reads it
    is_ret = 1'b1; is_wb = 1'b1; wr_adr = 4'd15; wr_data = 32'hCAFE_F00D;
    #1;
`ifdef RF_WR_BYPASS_EN
    chk("ret_wr_before_edge", op1, 32'hCAFE_F00D);
`else
    chk("ret_wr_before_edge", op1, 32'd150);
`endif
    tick();
    is_wb = 1'b0; #1;
    chk("ret_wr_after_edge", op1, 32'hCAFE_F00D);
    is_ret = 1'b0;

    // r0 is an ordinary writable register
    is_wb = 1'b1; wr_adr = 4'd0; wr_data = 32'hDEAD_BEEF;
    tick();
    is_wb = 1'b0;
    instruction = mk(4'd0, 4'd0, 4'd4, 32'h0);
    #1;
    chk("r0_writable", op1, 32'hDEAD_BEEF);
    chk("r4_held", op2, 32'd40);

    // 6: reset beats a simultaneous write
    reset = 1'b1; is_wb = 1'b1; wr_adr = 4'd2; wr_data = 32'd123;
    instruction = mk(4'd0, 4'd2, 4'd2, 32'h0);
    #1;
`ifdef RF_WR_BYPASS_EN
    chk("rst_no_bypass", op1, 32'd20);
`else
    chk("rst_no_bypass", op1, 32'd20);
`endif
    tick();
    reset = 1'b0; is_wb = 1'b0; #1;
    chk("rst_prio_r2", op1, 32'd0);
    instruction = mk(4'd0, 4'd5, 4'd0, 32'h0);
    is_ret = 1'b1; #1;
    chk("rst_clear_r15", op1, 32'd0);
    chk("rst_clear_r0", op2, 32'd0);
    is_ret = 1'b0; #1;
    chk("rst_clear_r5", op1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
